cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter WIDTH, default 31: data MSB index; result path is WIDTH+1 bits.
REQ-002 Parameter ROB, default 2: ROB tag MSB index.
REQ-003 Parameter NREQ, default 3: requester ports; 0=ALU, 1=branch, 2=reserved load unit.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 globalReset  input  1  synchronous active-high reset.
REQ-007 clear  input  1  pipeline flush on mispredict (controlFlow[0]).
REQ-008 fuValid  input  NREQ  per-port result valid.
REQ-009 fuResult  input  NREQ*(WIDTH+1)  per-port result; port i occupies bits [i*(WIDTH+1) +: WIDTH+1].
REQ-010 fuRob  input  NREQ*(ROB+1)  per-port ROB tag, packed the same way.
REQ-011 fuReady  output  NREQ  per-port accept; a transfer occurs when fuValid[i] and fuReady[i] are both high.
REQ-012 grant  output  NREQ  one-hot: holding entry selected this cycle; all zero if none.
REQ-013 validBroadcast  output  1  registered CDB valid.
REQ-014 result  output  WIDTH+1  registered CDB value.
REQ-015 robEntry  output  ROB+1  registered CDB ROB tag.

Function
REQ-016 Each port SHALL own a one-entry holding register {valid, result, rob}, loaded on an accepted transfer.
REQ-017 fuReady[i] SHALL equal !hold[i].valid OR grant[i] (combinational); it is independent of clear.
REQ-018 The arbiter SHALL select among valid holding entries only, never directly from fuValid.
REQ-019 Selection SHALL be round-robin: search starts at pointer ptr and wraps through indices ptr..NREQ-1, then 0..ptr-1.
REQ-020 At most one grant SHALL be raised per cycle.
REQ-021 On a grant to port g, ptr SHALL become (g+1) mod NREQ at the next edge. With no grant, ptr SHALL hold.
REQ-022 A granted entry SHALL clear at the next edge unless the same port transfers in that cycle, in which case the new data loads.
REQ-023 On a grant, the next edge SHALL register validBroadcast=1 with the granted result and rob. With no grant, validBroadcast SHALL be 0 and result/robEntry SHALL hold.
REQ-024 Latency: a transfer in cycle N SHALL give earliest validBroadcast in cycle N+2.
REQ-025 Throughput: each port SHALL sustain one transfer per cycle when it is the only requester.
REQ-026 clear SHALL invalidate all holding entries at the next edge and SHALL drop transfers accepted in the clear cycle. validBroadcast SHALL be 0 in the cycle after clear. ptr SHALL be unchanged.
REQ-027 grant SHALL be forced to zero while clear is high.
REQ-028 A valid holding entry SHALL not change while ungranted, whatever fuValid does.
REQ-029 Starvation bound: a valid entry SHALL be granted within NREQ cycles, absent clear.

Reset
REQ-030 globalReset SHALL take priority over clear and all transfers.
REQ-031 Reset values: all holding entries invalid, ptr=0, validBroadcast=0, result=0, robEntry=0.
REQ-032 In the reset cycle, fuReady SHALL read all ones and grant all zeros. Transfers in that cycle are discarded.

Structure
REQ-033 WIDTH, ROB and NREQ defaults SHALL live in the shared CPU package, together with the port-index constants ALU_PORT=0, BR_PORT=1, LD_PORT=2.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter. Inputs: request vector and ptr. Output: one-hot grant. It is purely combinational.
REQ-035 cdb_arbiter SHALL hold all state: holding registers, ptr and CDB output registers.

Verification
REQ-036 Single port: ALU transfers 0x0000_0005 with rob=3 in cycle 1 -> grant=001 in cycle 2; validBroadcast=1, result=5, robEntry=3 in cycle 3.
REQ-037 Contention: ALU (0xA, rob 1) and branch (0xB, rob 2) transfer together with ptr=0 -> ALU broadcast first, branch the next cycle; branch fuReady=0 until its grant; ptr ends at 2.
REQ-038 Round-robin: all three ports stream continuously for 9 cycles -> grants rotate 001,010,100 with no port skipped; each port sees fuReady=1 exactly on its grant cycle.
REQ-039 Flush: three entries held, then clear=1 together with an ALU transfer -> grant=000 that cycle; all entries empty and validBroadcast=0 next cycle; nothing from the flushed set is ever broadcast.
REQ-040 Reset mid-operation: globalReset while entries are held and validBroadcast=1 -> next cycle all outputs are at reset values and ptr=0.
REQ-041 Back-to-back on one port: branch transfers every cycle for 4 cycles alone -> 4 consecutive broadcasts in order with no bubble.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CPU constants for the common data bus: default widths and requester port indices.
package cdb_arbiter_pkg;
   localparam int WIDTH_DEF = 31;
   localparam int ROB_DEF   = 2;
   localparam int NREQ_DEF  = 3;

   localparam int ALU_PORT = 0;
   localparam int BR_PORT  = 1;
   localparam int LD_PORT  = 2;

   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping to index 0.
module rr_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int PTR_W = ptr_width(NREQ_DEF)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  grant
);

   int   idx;
   logic found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding register per functional unit, round-robin
// selection among held results, and a registered broadcast of the winner.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int ROB   = ROB_DEF,
   parameter int NREQ  = NREQ_DEF
) (
   input  logic                      clk,
   input  logic                      globalReset,
   input  logic                      clear,
   input  logic [NREQ-1:0]           fuValid,
   input  logic [NREQ*(WIDTH+1)-1:0] fuResult,
   input  logic [NREQ*(ROB+1)-1:0]   fuRob,
   output logic [NREQ-1:0]           fuReady,
   output logic [NREQ-1:0]           grant,
   output logic                      validBroadcast,
   output logic [WIDTH:0]            result,
   output logic [ROB:0]              robEntry
);

   localparam int PTR_W = ptr_width(NREQ);

   logic [NREQ-1:0]  hold_valid;
   logic [WIDTH:0]   hold_result [NREQ];
   logic [ROB:0]     hold_rob    [NREQ];
   logic [PTR_W-1:0] ptr;

   logic [NREQ-1:0]  rr_grant;
   logic             any_grant;
   logic [WIDTH:0]   sel_result;
   logic [ROB:0]     sel_rob;
   logic [PTR_W-1:0] ptr_next;

   rr_arbiter #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_rr (
      .req   (hold_valid),
      .ptr   (ptr),
      .grant (rr_grant)
   );

   // A granted entry frees its slot this cycle, so the same port may refill it.
   assign grant   = (clear || globalReset) ? '0 : rr_grant;
   assign fuReady = globalReset ? '1 : (~hold_valid | grant);

   always_comb begin
      any_grant  = |grant;
      sel_result = '0;
      sel_rob    = '0;
      ptr_next   = ptr;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_result = hold_result[i];
            sel_rob    = hold_rob[i];
            ptr_next   = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (globalReset) begin
         hold_valid     <= '0;
         ptr            <= '0;
         validBroadcast <= 1'b0;
         result         <= '0;
         robEntry       <= '0;
         for (int i = 0; i < NREQ; i++) begin
            hold_result[i] <= '0;
            hold_rob[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (clear) begin
               hold_valid[i] <= 1'b0;
            end else if (fuValid[i] && fuReady[i]) begin
               hold_valid[i]  <= 1'b1;
               hold_result[i] <= fuResult[i*(WIDTH+1) +: (WIDTH+1)];
               hold_rob[i]    <= fuRob[i*(ROB+1) +: (ROB+1)];
            end else if (grant[i]) begin
               hold_valid[i] <= 1'b0;
            end
         end
         validBroadcast <= any_grant;
         if (any_grant) begin
            result   <= sel_result;
            robEntry <= sel_rob;
            ptr      <= ptr_next;
         end
      end
   end

endmodule
